id_ex_stage: RTL and testbench

- ID/EX pipeline register that feeds the 8-bit ALU.
- Captures decoded operands and control, resolves operand forwarding from later stages, and decodes alu_op/funct into the ALU's 4-bit control code.
- Detects load-use hazards, inserts bubbles, and supports downstream stall and branch flush.

---
 rtl/id_ex_stage.sv | 171 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding, load-use bubble and ALU control decode
module id_ex_stage #(
    parameter int DATA_W  = 8,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               stall,
    input  logic               flush,
    input  logic [RADDR_W-1:0] rs_addr,
    input  logic [RADDR_W-1:0] rt_addr,
    input  logic [RADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0]  rs_data,
    input  logic [DATA_W-1:0]  rt_data,
    input  logic [DATA_W-1:0]  imm,
    input  logic [1:0]         alu_op,
    input  logic [5:0]         funct,
    input  logic               alu_src,
    input  logic               reg_dst,
    input  logic               reg_write,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic               mem_to_reg,
    input  logic [DATA_W-1:0]  ex_result,
    input  logic               mem_reg_write,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]  mem_result,
    input  logic               wb_reg_write,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               out_valid,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [3:0]         alu_control,
    output logic [DATA_W-1:0]  store_data,
    output logic [RADDR_W-1:0] dest_reg,
    output logic               reg_write_q,
    output logic               mem_read_q,
    output logic               mem_write_q,
    output logic               mem_to_reg_q,
    output logic               illegal_funct,
    output logic               hazard
);

    logic               r_out_valid;
    logic [DATA_W-1:0]  r_alu_a;
    logic [DATA_W-1:0]  r_alu_b;
    logic [3:0]         r_alu_control;
    logic [DATA_W-1:0]  r_store_data;
    logic [RADDR_W-1:0] r_dest_reg;
    logic               r_reg_write;
    logic               r_mem_read;
    logic               r_mem_write;
    logic               r_mem_to_reg;
    logic               r_illegal;

    logic               w_hazard;
    logic               w_ex_fwd_ok;
    logic [DATA_W-1:0]  w_fwd_rs;
    logic [DATA_W-1:0]  w_fwd_rt;
    logic [3:0]         w_ctl;
    logic               w_illegal;
    logic [RADDR_W-1:0] w_dest;

    // The held instruction can only forward its ALU result if it is not a load (load data is not ready yet)
    assign w_ex_fwd_ok = r_out_valid & r_reg_write & ~r_mem_read;

    // Forwarding priority: youngest producer first; register 0 always reads the register file
    function automatic logic [DATA_W-1:0] fwd(input logic [RADDR_W-1:0] addr, input logic [DATA_W-1:0] rf);
        if (addr == '0)
            return rf;
        if (w_ex_fwd_ok && r_dest_reg == addr)
            return ex_result;
        if (mem_reg_write && mem_rd == addr)
            return mem_result;
        if (wb_reg_write && wb_rd == addr)
            return wb_data;
        return rf;
    endfunction

    // Resolve both source operands and the destination register for the incoming instruction
    always_comb begin
        w_fwd_rs = fwd(rs_addr, rs_data);
        w_fwd_rt = fwd(rt_addr, rt_data);
        w_dest   = reg_dst ? rd_addr : rt_addr;
    end

    // A load held here whose destination is read by the incoming instruction forces a one-cycle bubble
    always_comb begin
        w_hazard = r_out_valid & r_mem_read & (r_dest_reg != '0) & in_valid &
                   ((rs_addr == r_dest_reg) | ((rt_addr == r_dest_reg) & (~alu_src | mem_write)));
    end

    // Translate the main-decoder class and R-type funct into the ALU control code
    always_comb begin
        w_illegal = 1'b0;
        w_ctl     = 4'b0010;
        case (alu_op)
            2'b00: w_ctl = 4'b0010;
            2'b01: w_ctl = 4'b0110;
            2'b11: w_ctl = 4'b0001;
            default: begin
                case (funct)
                    6'b100000: w_ctl = 4'b0010;
                    6'b100010: w_ctl = 4'b0110;
                    6'b100100: w_ctl = 4'b0000;
                    6'b100101: w_ctl = 4'b0001;
                    6'b100111: w_ctl = 4'b1100;
                    6'b011000: w_ctl = 4'b1101;
                    default: begin
                        w_ctl     = 4'b1111;
                        w_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Pipeline register: reset > flush > stall > hazard bubble > load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_control <= '0;
            r_store_data  <= '0;
            r_dest_reg    <= '0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_illegal     <= 1'b0;
        end else if (flush || (!stall && w_hazard)) begin
            r_out_valid  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (!stall) begin
            r_out_valid   <= in_valid;
            r_alu_a       <= w_fwd_rs;
            r_alu_b       <= alu_src ? imm : w_fwd_rt;
            r_alu_control <= w_ctl;
            r_store_data  <= w_fwd_rt;
            r_dest_reg    <= w_dest;
            r_reg_write   <= in_valid & reg_write;
            r_mem_read    <= in_valid & mem_read;
            r_mem_write   <= in_valid & mem_write;
            r_mem_to_reg  <= in_valid & mem_to_reg;
            r_illegal     <= in_valid & w_illegal;
        end
    end

    assign hazard        = w_hazard;
    assign in_ready      = ~stall & ~w_hazard;
    assign out_valid     = r_out_valid;
    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign alu_control   = r_alu_control;
    assign store_data    = r_store_data;
    assign dest_reg      = r_dest_reg;
    assign reg_write_q   = r_reg_write;
    assign mem_read_q    = r_mem_read;
    assign mem_write_q   = r_mem_write;
    assign mem_to_reg_q  = r_mem_to_reg;
    assign illegal_funct = r_illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for the ID/EX pipeline register
module tb_id_ex_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic [4:0] rs_addr = '0, rt_addr = '0, rd_addr = '0;
    logic [7:0] rs_data = '0, rt_data = '0, imm = '0;
    logic [1:0] alu_op = '0;
    logic [5:0] funct = '0;
    logic       alu_src = 1'b0, reg_dst = 1'b0, reg_write = 1'b0;
    logic       mem_read = 1'b0, mem_write = 1'b0, mem_to_reg = 1'b0;
    logic [7:0] ex_result = '0;
    logic       mem_reg_write = 1'b0;
    logic [4:0] mem_rd = '0;
    logic [7:0] mem_result = '0;
    logic       wb_reg_write = 1'b0;
    logic [4:0] wb_rd = '0;
    logic [7:0] wb_data = '0;
    logic       out_valid;
    logic [7:0] alu_a, alu_b, store_data;
    logic [3:0] alu_control;
    logic [4:0] dest_reg;
    logic       reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, illegal_funct, hazard;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] ctl;
        logic [4:0] dst;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       m2r;
        logic       ill;
        logic [7:0] sd;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   failures = 0;
    logic p_rw = 1'b0;
    logic [4:0] p_dst = '0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .stall(stall), .flush(flush), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rd_addr(rd_addr), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .alu_op(alu_op), .funct(funct), .alu_src(alu_src), .reg_dst(reg_dst),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .ex_result(ex_result), .mem_reg_write(mem_reg_write),
        .mem_rd(mem_rd), .mem_result(mem_result), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid), .alu_a(alu_a),
        .alu_b(alu_b), .alu_control(alu_control), .store_data(store_data),
        .dest_reg(dest_reg), .reg_write_q(reg_write_q), .mem_read_q(mem_read_q),
        .mem_write_q(mem_write_q), .mem_to_reg_q(mem_to_reg_q),
        .illegal_funct(illegal_funct), .hazard(hazard)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [7:0] rsd, input logic [7:0] rtd, input logic [7:0] im,
                             input logic [1:0] op, input logic [5:0] f, input logic src,
                             input logic dst, input logic rw, input logic mr, input logic mw,
                             input logic m2r);
        in_valid = 1'b1;
        rs_addr = rs; rt_addr = rt; rd_addr = rd;
        rs_data = rsd; rt_data = rtd; imm = im;
        alu_op = op; funct = f; alu_src = src; reg_dst = dst;
        reg_write = rw; mem_read = mr; mem_write = mw; mem_to_reg = m2r;
    endtask

    task automatic set_fwd(input logic [7:0] ex, input logic mrw, input logic [4:0] mrd,
                           input logic [7:0] mres, input logic wrw, input logic [4:0] wrd,
                           input logic [7:0] wd);
        ex_result = ex;
        mem_reg_write = mrw; mem_rd = mrd; mem_result = mres;
        wb_reg_write = wrw; wb_rd = wrd; wb_data = wd;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] ctl,
                        input logic [4:0] dst, input logic rw, input logic mr, input logic mw,
                        input logic m2r, input logic ill, input logic [7:0] sd);
        exp_t e;
        e = '{a: a, b: b, ctl: ctl, dst: dst, rw: rw, mr: mr, mw: mw, m2r: m2r, ill: ill, sd: sd};
        sb.push_back(e);
    endtask

    // Advance one edge and compare: exp_v = expected out_valid, hold = outputs must repeat the last result
    task automatic tick(input logic exp_v, input logic hold);
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, exp_v);
        if (exp_v) begin
            if (!hold) begin
                if (sb.size() == 0) chk("sb_empty", 0, 1);
                else cur = sb.pop_front();
            end
            chk("alu_a", alu_a, cur.a);
            chk("alu_b", alu_b, cur.b);
            chk("alu_control", alu_control, cur.ctl);
            chk("dest_reg", dest_reg, cur.dst);
            chk("reg_write_q", reg_write_q, cur.rw);
            chk("mem_read_q", mem_read_q, cur.mr);
            chk("mem_write_q", mem_write_q, cur.mw);
            chk("mem_to_reg_q", mem_to_reg_q, cur.m2r);
            chk("illegal_funct", illegal_funct, cur.ill);
            chk("store_data", store_data, cur.sd);
        end else begin
            chk("reg_write_q_clr", reg_write_q, 0);
            chk("mem_read_q_clr", mem_read_q, 0);
            chk("mem_write_q_clr", mem_write_q, 0);
            chk("mem_to_reg_q_clr", mem_to_reg_q, 0);
        end
    endtask

    function automatic logic [4:0] mdl_ctl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 5'h02;
        if (op == 2'b01) return 5'h06;
        if (op == 2'b11) return 5'h01;
        case (f)
            6'h20: return 5'h02;
            6'h22: return 5'h06;
            6'h24: return 5'h00;
            6'h25: return 5'h01;
            6'h27: return 5'h0C;
            6'h18: return 5'h0D;
            default: return 5'h1F;
        endcase
    endfunction

    function automatic logic [7:0] mdl_fwd(input logic [4:0] a, input logic [7:0] rf);
        if (a == 0) return rf;
        if (p_rw && p_dst == a) return ex_result;
        if (mem_reg_write && mem_rd == a) return mem_result;
        if (wb_reg_write && wb_rd == a) return wb_data;
        return rf;
    endfunction

    initial begin
        logic [5:0] fl [8];
        logic [4:0] c;
        logic [7:0] fa, fb;
        logic [4:0] d;
        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h18, 6'h07, 6'h3F};

        tick(1'b0, 1'b0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_control", alu_control, 0);
        chk("rst_dest_reg", dest_reg, 0);
        chk("rst_illegal", illegal_funct, 0);
        chk("rst_store_data", store_data, 0);
        chk("rst_hazard", hazard, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // R-type add writing r5
        set_instr(3, 4, 5, 8'h05, 8'h07, 8'h00, 2'b10, 6'h20, 0, 1, 1, 0, 0, 0);
        push(8'h05, 8'h07, 4'b0010, 5, 1, 0, 0, 0, 0, 8'h07);
        tick(1'b1, 1'b0);

        // Reads r5: EX beats MEM and WB
        set_instr(5, 4, 9, 8'h99, 8'h07, 8'h00, 2'b00, 6'h00, 0, 0, 1, 0, 0, 0);
        set_fwd(8'h2A, 1, 5, 8'h11, 1, 5, 8'h22);
        push(8'h2A, 8'h07, 4'b0010, 4, 1, 0, 0, 0, 0, 8'h07);
        tick(1'b1, 1'b0);

        // lw r6: rs=r5 now comes from MEM (held instr writes r4)
        set_instr(5, 6, 0, 8'h99, 8'h33, 8'h04, 2'b00, 6'h00, 1, 0, 1, 1, 0, 1);
        push(8'h11, 8'h04, 4'b0010, 6, 1, 1, 0, 1, 0, 8'h33);
        tick(1'b1, 1'b0);

        // Load-use on r6
        set_instr(6, 1, 7, 8'h99, 8'h44, 8'h00, 2'b10, 6'h22, 0, 1, 1, 0, 0, 0);
        set_fwd(8'h00, 0, 0, 8'h00, 0, 0, 8'h00);
        #1;
        chk("hazard_lu", hazard, 1);
        chk("in_ready_lu", in_ready, 0);
        tick(1'b0, 1'b0);
        set_fwd(8'h00, 1, 6, 8'h5A, 0, 0, 8'h00);
        #1;
        chk("hazard_after", hazard, 0);
        chk("in_ready_after", in_ready, 1);
        push(8'h5A, 8'h44, 4'b0110, 7, 1, 0, 0, 0, 0, 8'h44);
        tick(1'b1, 1'b0);

        // r0 guard
        set_instr(0, 2, 8, 8'h00, 8'h10, 8'h00, 2'b11, 6'h00, 0, 1, 1, 0, 1, 0);
        set_fwd(8'h77, 1, 0, 8'hFF, 1, 0, 8'hEE);
        push(8'h00, 8'h10, 4'b0001, 8, 1, 0, 1, 0, 0, 8'h10);
        tick(1'b1, 1'b0);

        // Stall two cycles, then flush while stalled
        set_instr(1, 2, 3, 8'hAB, 8'hCD, 8'h00, 2'b01, 6'h00, 0, 1, 1, 0, 0, 0);
        set_fwd(8'h00, 0, 0, 8'h00, 0, 0, 8'h00);
        stall = 1'b1;
        #1;
        chk("in_ready_stall", in_ready, 0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        flush = 1'b1;
        tick(1'b0, 1'b0);
        flush = 1'b0;
        stall = 1'b0;

        // Illegal funct with immediate operand; rt forwarding only reaches store_data
        set_instr(1, 7, 3, 8'h03, 8'h00, 8'hFC, 2'b10, 6'h07, 1, 1, 1, 0, 0, 0);
        set_fwd(8'h00, 1, 7, 8'h55, 0, 0, 8'h00);
        push(8'h03, 8'hFC, 4'b1111, 3, 1, 0, 0, 0, 1, 8'h55);
        tick(1'b1, 1'b0);
        in_valid = 1'b0;
        set_fwd(8'h00, 0, 0, 8'h00, 0, 0, 8'h00);
        tick(1'b0, 1'b0);

        // Full decode table
        for (int op = 0; op < 4; op++) begin
            for (int i = 0; i < 8; i++) begin
                set_instr(1, 2, 3, 8'h21, 8'h42, 8'h00, 2'(op), fl[i], 0, 1, 0, 0, 0, 0);
                c = mdl_ctl(2'(op), fl[i]);
                push(8'h21, 8'h42, c[3:0], 3, 0, 0, 0, 0, c[4], 8'h42);
                tick(1'b1, 1'b0);
            end
        end

        // Random forwarding mix (no loads, so no hazards)
        p_rw = 1'b0;
        for (int n = 0; n < 80; n++) begin
            set_instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)),
                      fl[$urandom_range(0, 7)], 1'($urandom), 1'($urandom), 1'($urandom),
                      0, 1'($urandom), 1'($urandom));
            set_fwd(8'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 8'($urandom),
                    1'($urandom), 5'($urandom_range(0, 3)), 8'($urandom));
            fa = mdl_fwd(rs_addr, rs_data);
            fb = mdl_fwd(rt_addr, rt_data);
            c = mdl_ctl(alu_op, funct);
            d = reg_dst ? rd_addr : rt_addr;
            push(fa, alu_src ? imm : fb, c[3:0], d, reg_write, 0, mem_write, mem_to_reg, c[4], fb);
            tick(1'b1, 1'b0);
            p_rw = reg_write;
            p_dst = d;
        end

        in_valid = 1'b0;
        tick(1'b0, 1'b0);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
